dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_pkg.sv | 20 ++
 rtl/rr_arbiter2.sv | 29 ++
 rtl/dmem_arbiter.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding, requester
// indices and default RAM geometry.
package dmem_pkg;

    localparam int unsigned DEFAULT_SIZE       = 64;
    localparam int unsigned DEFAULT_DATA_WIDTH = 32;
    localparam int unsigned ADDR_W             = 32;
    localparam int unsigned NUM_REQ            = 2;

    localparam int unsigned REQ_CPU = 0;
    localparam int unsigned REQ_LDR = 1;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } dmem_state_e;

endpackage : dmem_pkg

// File: rtl/rr_arbiter2.sv
// Two-way round-robin winner selection; the pointer names the requester that
// wins a tie, and the next pointer hands priority to the loser.
module rr_arbiter2
    import dmem_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               ptr_i,
    output logic [NUM_REQ-1:0] grant_c_o,
    output logic               ptr_next_c_o
);

    always_comb begin
        grant_c_o    = '0;
        ptr_next_c_o = ptr_i;
        unique case (req_i)
            2'b01:   grant_c_o[REQ_CPU] = 1'b1;
            2'b10:   grant_c_o[REQ_LDR] = 1'b1;
            2'b11: begin
                if (ptr_i) grant_c_o[REQ_LDR] = 1'b1;
                else       grant_c_o[REQ_CPU] = 1'b1;
            end
            default: grant_c_o = '0;
        endcase
        if (|req_i) begin
            ptr_next_c_o = ~grant_c_o[REQ_LDR];
        end
    end

endmodule : rr_arbiter2

// File: rtl/dmem_arbiter.sv
// Arbitrates CPU and loader/debug access to a single-port data RAM.
// Optional out-of-range detection is enabled with `define DMEM_ARB_RANGE_CHECK_EN.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned SIZE       = DEFAULT_SIZE,
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [1:0]                req,
    input  logic [1:0]                we,
    input  logic [63:0]               addr,
    input  logic [2*DATA_WIDTH-1:0]   wdata,
    output logic [1:0]                ack,
    output logic [DATA_WIDTH-1:0]     rdata,
    output logic [1:0]                err,
    output logic                      busy,
    output logic [31:0]               ram_address,
    output logic [DATA_WIDTH-1:0]     ram_data_write,
    output logic                      ram_write_en,
    output logic                      ram_read_en,
    input  logic [DATA_WIDTH-1:0]     ram_data_out
);

`ifdef DMEM_ARB_RANGE_CHECK_EN
    localparam logic RANGE_CHECK = 1'b1;
`else
    localparam logic RANGE_CHECK = 1'b0;
`endif

    dmem_state_e               state_q, state_d;
    logic                      ptr_q, ptr_d;
    logic                      win_q, win_d;
    logic                      we_q, we_d;
    logic                      oob_q, oob_d;
    logic [1:0]                ack_q, ack_d;
    logic [1:0]                err_q, err_d;
    logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
    logic                      busy_q, busy_d;
    logic [ADDR_W-1:0]         ram_addr_q, ram_addr_d;
    logic [DATA_WIDTH-1:0]     ram_wdata_q, ram_wdata_d;
    logic                      ram_wen_q, ram_wen_d;
    logic                      ram_ren_q, ram_ren_d;

    logic [NUM_REQ-1:0]        grant_c;
    logic                      ptr_next_c;
    logic                      win_sel_c;
    logic                      we_sel_c;
    logic                      oob_sel_c;
    logic [ADDR_W-1:0]         addr_sel_c;
    logic [DATA_WIDTH-1:0]     wdata_sel_c;

    rr_arbiter2 u_rr (
        .req_i        (req),
        .ptr_i        (ptr_q),
        .grant_c_o    (grant_c),
        .ptr_next_c_o (ptr_next_c)
    );

    // Steer the winning requester's lane; only meaningful while some req is high.
    always_comb begin
        win_sel_c   = grant_c[REQ_LDR];
        we_sel_c    = win_sel_c ? we[REQ_LDR] : we[REQ_CPU];
        addr_sel_c  = win_sel_c ? addr[2*ADDR_W-1:ADDR_W] : addr[ADDR_W-1:0];
        wdata_sel_c = win_sel_c ? wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                                : wdata[DATA_WIDTH-1:0];
        oob_sel_c   = RANGE_CHECK && (32'(addr_sel_c >> 2) >= 32'(SIZE));
    end

    // Next-state and registered-output logic; RAM strobes are registered on
    // acceptance so they are held stable for the whole ACCESS cycle.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        win_d       = win_q;
        we_d        = we_q;
        oob_d       = oob_q;
        ack_d       = '0;
        err_d       = '0;
        rdata_d     = '0;
        ram_addr_d  = '0;
        ram_wdata_d = '0;
        ram_wen_d   = 1'b0;
        ram_ren_d   = 1'b0;

        unique case (state_q)
            ST_INIT: begin
                state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (|req) begin
                    state_d     = ST_ACCESS;
                    ptr_d       = ptr_next_c;
                    win_d       = win_sel_c;
                    we_d        = we_sel_c;
                    oob_d       = oob_sel_c;
                    ram_addr_d  = addr_sel_c;
                    ram_wdata_d = wdata_sel_c;
                    ram_wen_d   = we_sel_c & ~oob_sel_c;
                    ram_ren_d   = ~we_sel_c & ~oob_sel_c;
                end
            end
            ST_ACCESS: begin
                state_d        = ST_DONE;
                ack_d[win_q]   = 1'b1;
                err_d[win_q]   = oob_q;
                if (!we_q && !oob_q) begin
                    rdata_d = ram_data_out;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_INIT;
            ptr_q       <= 1'b0;
            win_q       <= 1'b0;
            we_q        <= 1'b0;
            oob_q       <= 1'b0;
            ack_q       <= '0;
            err_q       <= '0;
            rdata_q     <= '0;
            busy_q      <= 1'b1;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_wen_q   <= 1'b0;
            ram_ren_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            win_q       <= win_d;
            we_q        <= we_d;
            oob_q       <= oob_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            busy_q      <= busy_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_wen_q   <= ram_wen_d;
            ram_ren_q   <= ram_ren_d;
        end
    end

    assign ack            = ack_q;
    assign err            = err_q;
    assign rdata          = rdata_q;
    assign busy           = busy_q;
    assign ram_address    = ram_addr_q;
    assign ram_data_write = ram_wdata_q;
    assign ram_write_en   = ram_wen_q;
    assign ram_read_en    = ram_ren_q;

endmodule : dmem_arbiter
